// File: rtl/dm_be.sv
// dm_be: single-port 32-bit data memory with byte/halfword/word access.
// Loads have one cycle of latency and optional sign extension. An optional
// clear sequence zeroes the whole array after reset.
//
// Ports:
//   clk       - clock, all state changes on the rising edge
//   rst       - synchronous active-high reset
//   en        - access request this cycle
//   we        - 1 = store, 0 = load (qualified by en)
//   size      - 00 byte, 01 halfword, 10 word, 11 reserved (rejected)
//   sext      - sign-extend (1) or zero-extend (0) byte/half loads
//   addr      - byte address
//   din       - right-justified store data
//   dout      - registered load result, holds while rvalid is low
//   rvalid    - one-cycle pulse per accepted load
//   misalign  - one-cycle pulse per rejected access
//   busy      - high while the clear sequence runs; requests are ignored
module dm_be #(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  sext,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           din,
    output logic [31:0]           dout,
    output logic                  rvalid,
    output logic                  misalign,
    output logic                  busy
);

    localparam int unsigned IDX_W = ADDR_WIDTH - 2;
    localparam int unsigned DEPTH = 1 << IDX_W;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [IDX_W-1:0] CNT_LAST = {IDX_W{1'b1}};

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [31:0]      dout_q, dout_d;
    logic             rvalid_q, rvalid_d;
    logic             misalign_q, misalign_d;

    logic [31:0]      mem_q [DEPTH];

    logic [IDX_W-1:0] idx_c;
    logic [1:0]       lane_c;
    logic             access_c;
    logic             misaligned_c;
    logic [31:0]      rd_word_c;
    logic [7:0]       rd_byte_c;
    logic [15:0]      rd_half_c;
    logic [31:0]      ld_data_c;

    logic             wr_en_c;
    logic [IDX_W-1:0] wr_idx_c;
    logic [31:0]      wr_data_c;
    logic [3:0]       wr_be_c;

    assign idx_c     = addr[ADDR_WIDTH-1:2];
    assign lane_c    = addr[1:0];
    assign access_c  = en && (state_q == ST_IDLE) && !rst;
    assign rd_word_c = mem_q[idx_c];

    // Alignment rules: halves need addr[0]=0, words need addr[1:0]=0, size 11 is never legal.
    always_comb begin
        misaligned_c = 1'b1;
        case (size)
            SZ_BYTE: misaligned_c = 1'b0;
            SZ_HALF: misaligned_c = addr[0];
            SZ_WORD: misaligned_c = (addr[1:0] != 2'b00);
            default: misaligned_c = 1'b1;
        endcase
    end

    // Load lane extraction and extension (little-endian lanes).
    always_comb begin
        rd_byte_c = 8'h00;
        case (lane_c)
            2'd0:    rd_byte_c = rd_word_c[7:0];
            2'd1:    rd_byte_c = rd_word_c[15:8];
            2'd2:    rd_byte_c = rd_word_c[23:16];
            default: rd_byte_c = rd_word_c[31:24];
        endcase
        rd_half_c = addr[1] ? rd_word_c[31:16] : rd_word_c[15:0];

        ld_data_c = rd_word_c;
        case (size)
            SZ_BYTE: ld_data_c = sext ? {{24{rd_byte_c[7]}}, rd_byte_c}
                                      : {24'h000000, rd_byte_c};
            SZ_HALF: ld_data_c = sext ? {{16{rd_half_c[15]}}, rd_half_c}
                                      : {16'h0000, rd_half_c};
            default: ld_data_c = rd_word_c;
        endcase
    end

    // Next-state, write-port and output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dout_d     = dout_q;
        rvalid_d   = 1'b0;
        misalign_d = 1'b0;
        wr_en_c    = 1'b0;
        wr_idx_c   = idx_c;
        wr_data_c  = 32'h0000_0000;
        wr_be_c    = 4'b0000;

        case (state_q)
            ST_CLEAR: begin
                wr_en_c  = 1'b1;
                wr_idx_c = cnt_q;
                wr_be_c  = 4'b1111;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            default: begin
                if (access_c) begin
                    if (misaligned_c) begin
                        misalign_d = 1'b1;
                    end else if (we) begin
                        wr_en_c = 1'b1;
                        case (size)
                            SZ_BYTE: begin
                                wr_data_c = {4{din[7:0]}};
                                wr_be_c   = 4'b0001 << lane_c;
                            end
                            SZ_HALF: begin
                                wr_data_c = {2{din[15:0]}};
                                wr_be_c   = addr[1] ? 4'b1100 : 4'b0011;
                            end
                            default: begin
                                wr_data_c = din;
                                wr_be_c   = 4'b1111;
                            end
                        endcase
                    end else begin
                        rvalid_d = 1'b1;
                        dout_d   = ld_data_c;
                    end
                end
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            cnt_q      <= '0;
            dout_q     <= 32'h0000_0000;
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            rvalid_q   <= rvalid_d;
            misalign_q <= misalign_d;
        end
    end

    // Storage array: no reset so contents survive reset when clearing is disabled.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_en_c && !rst && wr_be_c[k]) begin
                mem_q[wr_idx_c][8*k +: 8] <= wr_data_c[8*k +: 8];
            end
        end
    end

    assign dout     = dout_q;
    assign rvalid   = rvalid_q;
    assign misalign = misalign_q;
    assign busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_dm_be.sv
// tb_dm_be: randomized and directed stimulus for dm_be, checked against a
// byte-addressed behavioural model of the memory, clear timer and outputs.
module tb_dm_be;

    localparam int unsigned AW    = 12;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned NBYTE = 4096;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          we;
    logic [1:0]    size;
    logic          sext;
    logic [AW-1:0] addr;
    logic [31:0]   din;
    logic [31:0]   dout;
    logic          rvalid;
    logic          misalign;
    logic          busy;

    always #5 clk = ~clk;

    dm_be #(.ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .we       (we),
        .size     (size),
        .sext     (sext),
        .addr     (addr),
        .din      (din),
        .dout     (dout),
        .rvalid   (rvalid),
        .misalign (misalign),
        .busy     (busy)
    );

    // Reference model state
    logic [7:0]  mb [NBYTE];
    int          busy_left;
    logic [31:0] e_dout;
    logic        e_rv;
    logic        e_mis;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sx, input int a);
        logic [7:0]  b;
        logic [15:0] h;
        case (sz)
            2'd0: begin
                b = mb[a];
                return sx ? {{24{b[7]}}, b} : {24'h000000, b};
            end
            2'd1: begin
                h = {mb[a+1], mb[a]};
                return sx ? {{16{h[15]}}, h} : {16'h0000, h};
            end
            default: return {mb[a+3], mb[a+2], mb[a+1], mb[a]};
        endcase
    endfunction

    // One clock: drive at negedge, update model for the edge, check at next negedge.
    task automatic step(input logic t_rst, input logic t_en, input logic t_we,
                        input logic [1:0] t_sz, input logic t_sx,
                        input logic [AW-1:0] t_a, input logic [31:0] t_d);
        bit acc, bad;
        int a;
        rst = t_rst; en = t_en; we = t_we; size = t_sz; sext = t_sx; addr = t_a; din = t_d;
        a   = int'(t_a);
        acc = t_en && (busy_left == 0) && !t_rst;
        bad = (t_sz == 2'd3) || (t_sz == 2'd1 && t_a[0]) || (t_sz == 2'd2 && t_a[1:0] != 2'b00);
        if (t_rst) begin
            e_dout = 32'h0; e_rv = 1'b0; e_mis = 1'b0; busy_left = DEPTH;
            foreach (mb[i]) mb[i] = 8'h00;
        end else begin
            if (busy_left > 0) busy_left--;
            e_rv = 1'b0; e_mis = 1'b0;
            if (acc) begin
                if (bad) begin
                    e_mis = 1'b1;
                end else if (t_we) begin
                    case (t_sz)
                        2'd0: mb[a] = t_d[7:0];
                        2'd1: begin mb[a] = t_d[7:0]; mb[a+1] = t_d[15:8]; end
                        default: begin
                            mb[a] = t_d[7:0];   mb[a+1] = t_d[15:8];
                            mb[a+2] = t_d[23:16]; mb[a+3] = t_d[31:24];
                        end
                    endcase
                end else begin
                    e_rv   = 1'b1;
                    e_dout = model_load(t_sz, t_sx, a);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_eq("busy",     32'(busy),     32'(busy_left > 0));
        check_eq("rvalid",   32'(rvalid),   32'(e_rv));
        check_eq("misalign", 32'(misalign), 32'(e_mis));
        check_eq("dout",     dout,          e_dout);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, '0, 32'h0);
    endtask

    task automatic rand_step_no_rst();
        step(1'b0, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
             AW'($urandom), $urandom);
    endtask

    task automatic store(input logic [1:0] sz, input logic [AW-1:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, 1'b1, sz, 1'b0, a, d);
    endtask

    task automatic load(input logic [1:0] sz, input logic sx, input logic [AW-1:0] a);
        step(1'b0, 1'b1, 1'b0, sz, sx, a, 32'h0);
    endtask

    // Wait out a clear with random requests; count busy samples including the reset one.
    task automatic count_busy(input string tag);
        int bc;
        bc = busy ? 1 : 0;
        for (int i = 0; i < 1100 && busy; i++) begin
            rand_step_no_rst();
            if (busy) bc++;
        end
        check_eq(tag, 32'(bc), 32'(DEPTH));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; we = 1'b0; size = 2'd0; sext = 1'b0; addr = '0; din = '0;
        busy_left = DEPTH; e_dout = '0; e_rv = 1'b0; e_mis = 1'b0;
        foreach (mb[i]) mb[i] = 8'h00;
        @(negedge clk);

        // Reset and full clear
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, '0, 32'h0);
        check_eq("rst_dout", dout, 32'h0);
        count_busy("busy_len_first");
        load(2'd2, 1'b0, 12'hFFC);
        check_eq("ld_ffc", dout, 32'h0000_0000);
        check_eq("ld_ffc_rv", 32'(rvalid), 32'd1);

        // Byte merge into a word
        store(2'd2, 12'h010, 32'h1122_3344);
        store(2'd0, 12'h012, 32'h0000_00AA);
        load(2'd2, 1'b0, 12'h010);
        check_eq("merge", dout, 32'h11AA_3344);

        // Sub-word extraction and extension
        store(2'd2, 12'h020, 32'h8000_F0FF);
        load(2'd0, 1'b1, 12'h020); check_eq("lb",  dout, 32'hFFFF_FFFF);
        load(2'd0, 1'b0, 12'h021); check_eq("lbu", dout, 32'h0000_00F0);
        load(2'd1, 1'b1, 12'h022); check_eq("lh",  dout, 32'hFFFF_8000);
        load(2'd1, 1'b0, 12'h022); check_eq("lhu", dout, 32'h0000_8000);

        // Misaligned / reserved accesses
        store(2'd2, 12'h030, 32'hCAFE_BABE);
        store(2'd2, 12'h040, 32'h0BAD_F00D);
        store(2'd1, 12'h031, 32'h1234_5678); check_eq("mis_h", 32'(misalign), 32'd1);
        store(2'd2, 12'h032, 32'h1234_5678); check_eq("mis_w", 32'(misalign), 32'd1);
        store(2'd3, 12'h040, 32'h1234_5678); check_eq("mis_r", 32'(misalign), 32'd1);
        load(2'd3, 1'b0, 12'h040);           check_eq("mis_rl", 32'(rvalid), 32'd0);
        idle();                              check_eq("mis_pulse", 32'(misalign), 32'd0);
        load(2'd2, 1'b0, 12'h030); check_eq("mis_keep30", dout, 32'hCAFE_BABE);
        load(2'd2, 1'b0, 12'h040); check_eq("mis_keep40", dout, 32'h0BAD_F00D);

        // Back-to-back loads
        store(2'd2, 12'h000, 32'hA0A0_0000);
        store(2'd2, 12'h004, 32'hA1A1_0004);
        store(2'd2, 12'h008, 32'hA2A2_0008);
        store(2'd2, 12'h00C, 32'hA3A3_000C);
        load(2'd2, 1'b0, 12'h000); check_eq("b2b0", dout, 32'hA0A0_0000);
        load(2'd2, 1'b0, 12'h004); check_eq("b2b1", dout, 32'hA1A1_0004);
        load(2'd2, 1'b0, 12'h008); check_eq("b2b2", dout, 32'hA2A2_0008);
        load(2'd2, 1'b0, 12'h00C); check_eq("b2b3", dout, 32'hA3A3_000C);
        idle(); check_eq("hold_dout", dout, 32'hA3A3_000C);

        // Request with reset asserted is discarded
        step(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 12'h004, 32'h0);
        check_eq("rst_load_rv", 32'(rvalid), 32'd0);

        // Reset restarted mid-clear
        for (int i = 0; i < 499; i++) rand_step_no_rst();
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, '0, 32'h0);
        count_busy("busy_len_restart");
        load(2'd2, 1'b0, 12'h010); check_eq("cleared10", dout, 32'h0);
        load(2'd2, 1'b0, 12'h00C); check_eq("cleared0c", dout, 32'h0);

        // Random traffic, mostly in a small window to get read-after-write hits
        for (int i = 0; i < 3000; i++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 63));
            if ($urandom_range(0, 999) == 0) begin
                step(1'b1, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
            end else begin
                step(1'b0, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
